// File: rtl/trace_pkg.sv
// trace_pkg: shared state encodings, capture modes and entry layout
// for the retire-trace recorder.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_STOP = 1'b1;

  localparam int TRC_ADDR_W = 32;
  localparam int TRC_DATA_W = 32;
  localparam int TRC_REG_AW = 5;

  function automatic int entry_w(
    input int aw,
    input int dw,
    input int rw
  );
    return aw + dw + 1 + rw + dw;
  endfunction

  localparam int ENTRY_W = entry_w(TRC_ADDR_W, TRC_DATA_W, TRC_REG_AW);

  // entry = {pc, instr, wb_en, wb_addr, wb_data}, wb_data at bit 0
  localparam int OFF_WB_DATA = 0;
  localparam int OFF_WB_ADDR = OFF_WB_DATA + TRC_DATA_W;
  localparam int OFF_WB_EN   = OFF_WB_ADDR + TRC_REG_AW;
  localparam int OFF_INSTR   = OFF_WB_EN + 1;
  localparam int OFF_PC      = OFF_INSTR + TRC_DATA_W;

endpackage

// File: rtl/trace_ram.sv
// trace_ram: simple dual-port trace storage, synchronous write and read.
// A same-address write is forwarded to the read port.
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) rdata <= '0;
    else if (we && waddr == raddr) rdata <= wdata;
    else rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer: retire-trace recorder with PC trigger,
// wrap/stop capture modes and an oldest-first valid/ready drain port.
module trace_capture_buffer
  import trace_pkg::*;
#(
  parameter int ADDR_W = TRC_ADDR_W,
  parameter int DATA_W = TRC_DATA_W,
  parameter int REG_AW = TRC_REG_AW,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ret_valid,
  input  logic [ADDR_W-1:0]       ret_pc,
  input  logic [DATA_W-1:0]       ret_instr,
  input  logic                    ret_wb_en,
  input  logic [REG_AW-1:0]       ret_wb_addr,
  input  logic [DATA_W-1:0]       ret_wb_data,
  input  logic                    cfg_mode,
  input  logic                    cfg_trig_en,
  input  logic [ADDR_W-1:0]       cfg_trig_pc,
  input  logic [$clog2(DEPTH):0]  cfg_post_cnt,
  input  logic                    cmd_arm,
  input  logic                    cmd_stop,
  input  logic                    cmd_clear,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [ADDR_W-1:0]       rd_pc,
  output logic [DATA_W-1:0]       rd_instr,
  output logic                    rd_wb_en,
  output logic [REG_AW-1:0]       rd_wb_addr,
  output logic [DATA_W-1:0]       rd_wb_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic [CNT_W-1:0]        dropped,
  output logic                    triggered,
  output logic [1:0]              state_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = entry_w(ADDR_W, DATA_W, REG_AW);

  trace_state_e state_q, state_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    post_q, post_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             trig_q, trig_d;

  logic              mode_q, trig_en_q;
  logic [ADDR_W-1:0] trig_pc_q;
  logic [CW-1:0]     post_cfg_q;

  logic          full, active, stop_full;
  logic          hit, cap, pop, arm, we;
  logic [EW-1:0] wdata, rdata;

  logic [ADDR_W-1:0] e_pc;
  logic [DATA_W-1:0] e_instr, e_wb_data;
  logic              e_wb_en;
  logic [REG_AW-1:0] e_wb_addr;

  assign full      = count_q == CW'(DEPTH);
  assign active    = state_q == ST_ARMED
                  || state_q == ST_POST;
  assign stop_full = active && full
                  && mode_q == MODE_STOP;
  assign hit       = state_q == ST_ARMED
                  && trig_en_q && ret_valid
                  && ret_pc == trig_pc_q;
  assign cap       = active && ret_valid
                  && !stop_full
                  && !(state_q == ST_POST
                       && post_q == '0);
  assign rd_valid  = state_q == ST_DONE
                  && count_q != '0;
  assign pop       = rd_valid && rd_ready;
  assign arm       = state_q == ST_IDLE
                  && cmd_arm && !cmd_clear;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    post_d  = post_q;
    drop_d  = drop_q;
    trig_d  = trig_q;
    we      = 1'b0;
    if (cmd_clear) begin
      state_d = ST_IDLE;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      drop_d  = '0;
      trig_d  = 1'b0;
    end else begin
      if (cap) begin
        we     = 1'b1;
        tail_d = tail_q + 1'b1;
        if (full) begin
          head_d = head_q + 1'b1;
          if (drop_q != '1) drop_d = drop_q + 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      if (pop) begin
        head_d  = head_q + 1'b1;
        count_d = count_q - 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_arm) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (cmd_stop || stop_full) begin
            state_d = ST_DONE;
          end else if (hit) begin
            state_d = ST_POST;
            trig_d  = 1'b1;
            post_d  = post_cfg_q;
          end
        end
        ST_POST: begin
          if (cmd_stop || stop_full
              || post_q == '0) begin
            state_d = ST_DONE;
          end else if (ret_valid) begin
            post_d = post_q - 1'b1;
            if (post_q == CW'(1)) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      post_q     <= '0;
      drop_q     <= '0;
      trig_q     <= 1'b0;
      mode_q     <= MODE_WRAP;
      trig_en_q  <= 1'b0;
      trig_pc_q  <= '0;
      post_cfg_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      post_q  <= post_d;
      drop_q  <= drop_d;
      trig_q  <= trig_d;
      if (arm) begin
        mode_q     <= cfg_mode;
        trig_en_q  <= cfg_trig_en;
        trig_pc_q  <= cfg_trig_pc;
        post_cfg_q <= cfg_post_cnt;
      end
    end
  end

  assign wdata = {ret_pc, ret_instr, ret_wb_en,
                  ret_wb_addr, ret_wb_data};

  // next head is prefetched so rd_* comes straight from the RAM register
  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (tail_q),
    .wdata (wdata),
    .raddr (head_d),
    .rdata (rdata)
  );

  assign {e_pc, e_instr, e_wb_en,
          e_wb_addr, e_wb_data} = rdata;

  assign rd_pc      = rd_valid ? e_pc      : '0;
  assign rd_instr   = rd_valid ? e_instr   : '0;
  assign rd_wb_en   = rd_valid ? e_wb_en   : 1'b0;
  assign rd_wb_addr = rd_valid ? e_wb_addr : '0;
  assign rd_wb_data = rd_valid ? e_wb_data : '0;

  assign count     = count_q;
  assign dropped   = drop_q;
  assign triggered = trig_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// tb_trace_capture_buffer: randomized scenarios checked against a
// queue-based model of the trace recorder.
module tb_trace_capture_buffer;

  localparam int DEPTH = 64;
  localparam int MAXD  = 65535;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ret_valid, ret_wb_en;
  logic [31:0] ret_pc, ret_instr, ret_wb_data;
  logic [4:0]  ret_wb_addr;
  logic        cfg_mode, cfg_trig_en;
  logic [31:0] cfg_trig_pc;
  logic [6:0]  cfg_post_cnt;
  logic        cmd_arm, cmd_stop, cmd_clear;
  logic        rd_valid, rd_ready, rd_wb_en;
  logic [31:0] rd_pc, rd_instr, rd_wb_data;
  logic [4:0]  rd_wb_addr;
  logic [6:0]  count;
  logic [15:0] dropped;
  logic        triggered;
  logic [1:0]  state_o;

  int vectors = 0;
  int errors  = 0;

  ent_t mq[$];
  int   m_st, m_post, m_drop, m_pcfg;
  bit   m_trig, m_mode, m_ten;
  logic [31:0] m_tpc;

  ent_t got[$];
  bit   d_unstable;

  trace_capture_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .ret_valid    (ret_valid),
    .ret_pc       (ret_pc),
    .ret_instr    (ret_instr),
    .ret_wb_en    (ret_wb_en),
    .ret_wb_addr  (ret_wb_addr),
    .ret_wb_data  (ret_wb_data),
    .cfg_mode     (cfg_mode),
    .cfg_trig_en  (cfg_trig_en),
    .cfg_trig_pc  (cfg_trig_pc),
    .cfg_post_cnt (cfg_post_cnt),
    .cmd_arm      (cmd_arm),
    .cmd_stop     (cmd_stop),
    .cmd_clear    (cmd_clear),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_pc        (rd_pc),
    .rd_instr     (rd_instr),
    .rd_wb_en     (rd_wb_en),
    .rd_wb_addr   (rd_wb_addr),
    .rd_wb_data   (rd_wb_data),
    .count        (count),
    .dropped      (dropped),
    .triggered    (triggered),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ent_t mk(input logic [31:0] pc);
    ent_t e;
    e.pc      = pc;
    e.instr   = $urandom;
    e.wb_en   = 1'($urandom_range(0, 1));
    e.wb_addr = 5'($urandom_range(0, 31));
    e.wb_data = $urandom;
    return e;
  endfunction

  function automatic logic [31:0] seq_pc(input int k);
    return 32'h0040_0000 + 32'(4 * k);
  endfunction

  // Model states: 0 idle, 1 armed, 2 post-trigger, 3 done
  task automatic model_step(input bit rv, input ent_t e,
                            input bit stop);
    bit full;
    full = mq.size() == DEPTH;
    if (m_st != 1 && m_st != 2) return;
    if (m_st == 2 && m_post == 0) begin
      m_st = 3;
      return;
    end
    if (full && m_mode) begin
      m_st = 3;
      return;
    end
    if (rv) begin
      if (full) begin
        void'(mq.pop_front());
        if (m_drop < MAXD) m_drop++;
      end
      mq.push_back(e);
    end
    if (stop) begin
      m_st = 3;
    end else if (m_st == 1 && m_ten && rv
                 && e.pc == m_tpc) begin
      m_trig = 1;
      m_post = m_pcfg;
      m_st   = 2;
    end else if (m_st == 2 && rv) begin
      m_post--;
      if (m_post == 0) m_st = 3;
    end
  endtask

  task automatic model_clear;
    mq.delete();
    m_st   = 0;
    m_drop = 0;
    m_trig = 0;
  endtask

  task automatic step(input bit rv, input ent_t e,
                      input bit stop);
    ret_valid   = rv;
    ret_pc      = e.pc;
    ret_instr   = e.instr;
    ret_wb_en   = e.wb_en;
    ret_wb_addr = e.wb_addr;
    ret_wb_data = e.wb_data;
    cmd_stop    = stop;
    @(posedge clk);
    model_step(rv, e, stop);
    #1;
    ret_valid = 1'b0;
    cmd_stop  = 1'b0;
  endtask

  task automatic arm(input bit mode, input bit ten,
                     input logic [31:0] tpc,
                     input int pcnt);
    cfg_mode     = mode;
    cfg_trig_en  = ten;
    cfg_trig_pc  = tpc;
    cfg_post_cnt = 7'(pcnt);
    cmd_arm      = 1'b1;
    @(posedge clk);
    if (m_st == 0) begin
      m_st   = 1;
      m_mode = mode;
      m_ten  = ten;
      m_tpc  = tpc;
      m_pcfg = pcnt;
    end
    #1;
    cmd_arm = 1'b0;
  endtask

  task automatic clear;
    cmd_clear = 1'b1;
    @(posedge clk);
    model_clear();
    #1;
    cmd_clear = 1'b0;
  endtask

  // Collects drained entries into got[]; bp enables random backpressure
  task automatic drain(input bit bp);
    ent_t cur;
    bit   rdy;
    got.delete();
    d_unstable = 0;
    for (int c = 0; c < 400; c++) begin
      if (!rd_valid) break;
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      cur = {rd_pc, rd_instr, rd_wb_en,
             rd_wb_addr, rd_wb_data};
      rd_ready = rdy;
      if (rdy) got.push_back(cur);
      @(posedge clk);
      #1;
      if (!rdy && cur !== {rd_pc, rd_instr, rd_wb_en,
                           rd_wb_addr, rd_wb_data})
        d_unstable = 1;
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (state_o !== 2'd0 || count !== 7'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d count=%0d want 0 0",
               state_o, count);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (dropped !== 16'd0 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: dropped=%0d trig=%0b want 0 0",
               dropped, triggered);
    end
    vectors++;
    if (rd_valid !== 1'b0 || rd_pc !== 32'd0
        || rd_wb_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_rd: valid=%0b pc=%h data=%h want 0",
               rd_valid, rd_pc, rd_wb_data);
    end
    model_clear();
  endtask

  task automatic test_wrap_basic;
    clear();
    arm(0, 0, 32'd0, 0);
    for (int k = 0; k < 5; k++) step(1, mk(seq_pc(k)), 0);
    step(0, '0, 1);
    vectors++;
    if (state_o !== 2'd3 || count !== 7'd5) begin
      errors++;
      $display("FAIL basic_stop: state=%0d count=%0d want 3 5",
               state_o, count);
    end
    cmd_arm = 1'b1;
    @(posedge clk);
    #1;
    cmd_arm = 1'b0;
    vectors++;
    if (state_o !== 2'd3) begin
      errors++;
      $display("FAIL arm_in_done: state=%0d want 3", state_o);
    end
    drain(0);
    vectors++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL basic_len: got %0d want 5", got.size());
    end
    for (int i = 0; i < got.size() && i < mq.size(); i++) begin
      vectors++;
      if (got[i] !== mq[i]) begin
        errors++;
        $display("FAIL basic_entry%0d: got %h want %h",
                 i, got[i], mq[i]);
      end
    end
    vectors++;
    if (rd_valid !== 1'b0 || count !== 7'd0) begin
      errors++;
      $display("FAIL basic_empty: valid=%0b count=%0d want 0 0",
               rd_valid, count);
    end
  endtask

  task automatic test_wrap_overflow;
    clear();
    arm(0, 0, 32'd0, 0);
    for (int k = 0; k < 70; k++) step(1, mk(seq_pc(k)), 0);
    step(0, '0, 1);
    vectors++;
    if (count !== 7'd64 || dropped !== 16'd6) begin
      errors++;
      $display("FAIL wrap_cnt: count=%0d dropped=%0d want 64 6",
               count, dropped);
    end
    vectors++;
    if (rd_pc !== 32'h0040_0018) begin
      errors++;
      $display("FAIL wrap_first: pc=%h want 00400018", rd_pc);
    end
    drain(0);
    vectors++;
    if (got.size() != mq.size()) begin
      errors++;
      $display("FAIL wrap_len: got %0d want %0d",
               got.size(), mq.size());
    end
    for (int i = 0; i < got.size() && i < mq.size(); i++) begin
      vectors++;
      if (got[i] !== mq[i]) begin
        errors++;
        $display("FAIL wrap_entry%0d: got %h want %h",
                 i, got[i], mq[i]);
      end
    end
  endtask

  task automatic test_stop_full;
    clear();
    arm(1, 0, 32'd0, 0);
    for (int k = 0; k < 70; k++) step(1, mk(seq_pc(k)), 0);
    vectors++;
    if (state_o !== 2'd3 || count !== 7'd64
        || dropped !== 16'd0) begin
      errors++;
      $display("FAIL stopfull: st=%0d cnt=%0d drop=%0d want 3 64 0",
               state_o, count, dropped);
    end
    drain(0);
    vectors++;
    if (got.size() != 64 || got[got.size()-1].pc !== 32'h0040_00FC)
    begin
      errors++;
      $display("FAIL stopfull_last: len=%0d want 64 last 004000fc",
               got.size());
    end
    for (int i = 0; i < got.size() && i < mq.size(); i++) begin
      vectors++;
      if (got[i] !== mq[i]) begin
        errors++;
        $display("FAIL stopfull_entry%0d: got %h want %h",
                 i, got[i], mq[i]);
      end
    end
  endtask

  task automatic test_trigger_post;
    clear();
    arm(0, 1, 32'h0040_0020, 3);
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 2) == 0) step(0, mk(32'hFFFF_FFF0), 0);
      step(1, mk(seq_pc(k)), 0);
    end
    vectors++;
    if (triggered !== 1'b1 || state_o !== 2'd3
        || count !== 7'd12) begin
      errors++;
      $display("FAIL trig: trig=%0b st=%0d cnt=%0d want 1 3 12",
               triggered, state_o, count);
    end
    drain(0);
    vectors++;
    if (got.size() != 12 || got[got.size()-1].pc !== 32'h0040_002C)
    begin
      errors++;
      $display("FAIL trig_last: len=%0d want 12 last 0040002c",
               got.size());
    end
    for (int i = 0; i < got.size() && i < mq.size(); i++) begin
      vectors++;
      if (got[i] !== mq[i]) begin
        errors++;
        $display("FAIL trig_entry%0d: got %h want %h",
                 i, got[i], mq[i]);
      end
    end
  endtask

  task automatic test_post_zero;
    ent_t e, te;
    clear();
    arm(0, 1, 32'h0040_0010, 0);
    te = '0;
    for (int k = 0; k < 10; k++) begin
      e = mk(seq_pc(k));
      if (k == 4) begin
        e.wb_en   = 1'b1;
        e.wb_addr = 5'd8;
        e.wb_data = 32'hDEAD_BEEF;
        te = e;
      end
      step(1, e, 0);
    end
    vectors++;
    if (state_o !== 2'd3 || count !== 7'd5) begin
      errors++;
      $display("FAIL post0: st=%0d cnt=%0d want 3 5",
               state_o, count);
    end
    drain(0);
    vectors++;
    if (got.size() != 5 || got[got.size()-1] !== te) begin
      errors++;
      $display("FAIL post0_last: len=%0d want 5, last entry %h",
               got.size(), te);
    end
  endtask

  task automatic test_reset_mid_post;
    clear();
    arm(0, 1, seq_pc(3), 20);
    for (int k = 0; k < 10; k++) step(1, mk(seq_pc(k)), 0);
    vectors++;
    if (state_o !== 2'd2 || count !== 7'd10) begin
      errors++;
      $display("FAIL midpost: st=%0d cnt=%0d want 2 10",
               state_o, count);
    end
    reset     = 1'b1;
    cmd_clear = 1'b1;
    cmd_stop  = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    cmd_clear = 1'b0;
    cmd_stop  = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    vectors++;
    if (state_o !== 2'd0 || count !== 7'd0 || dropped !== 16'd0
        || triggered !== 1'b0 || rd_valid !== 1'b0
        || rd_pc !== 32'd0) begin
      errors++;
      $display("FAIL rst_post: st=%0d cnt=%0d trig=%0b v=%0b",
               state_o, count, triggered, rd_valid);
    end
  endtask

  task automatic test_clear_priority;
    clear();
    arm(0, 0, 32'd0, 0);
    for (int k = 0; k < 3; k++) step(1, mk(seq_pc(k)), 0);
    cmd_clear = 1'b1;
    step(1, mk(seq_pc(3)), 1);
    cmd_clear = 1'b0;
    model_clear();
    vectors++;
    if (state_o !== 2'd0 || count !== 7'd0 || rd_valid !== 1'b0)
    begin
      errors++;
      $display("FAIL clear_prio: st=%0d cnt=%0d v=%0b want 0 0 0",
               state_o, count, rd_valid);
    end
  endtask

  task automatic test_random;
    bit rv, st, mode, ten;
    int pcnt;
    logic [31:0] tpc;
    for (int r = 0; r < 16; r++) begin
      clear();
      mode = 1'($urandom_range(0, 1));
      ten  = 1'($urandom_range(0, 3) != 0);
      tpc  = seq_pc($urandom_range(0, 40));
      pcnt = $urandom_range(0, 8);
      arm(mode, ten, tpc, pcnt);
      for (int c = 0; c < 160 && m_st != 3; c++) begin
        rv = $urandom_range(0, 3) != 0;
        st = $urandom_range(0, 119) == 0;
        cfg_mode     = 1'($urandom_range(0, 1));
        cfg_trig_en  = 1'($urandom_range(0, 1));
        cfg_trig_pc  = seq_pc($urandom_range(0, 40));
        cfg_post_cnt = 7'($urandom_range(0, 64));
        cmd_arm      = 1'($urandom_range(0, 1));
        step(rv, mk(seq_pc($urandom_range(0, 40))), st);
        vectors++;
        if (state_o !== 2'(m_st) || count !== 7'(mq.size())
            || dropped !== 16'(m_drop)
            || triggered !== m_trig) begin
          errors++;
          $display("FAIL rnd%0d_c%0d: st=%0d cnt=%0d drop=%0d tr=%0b want %0d %0d %0d %0b",
                   r, c, state_o, count, dropped, triggered,
                   m_st, mq.size(), m_drop, m_trig);
        end
      end
      cmd_arm = 1'b0;
      if (m_st != 3) step(0, '0, 1);
      drain(1);
      vectors++;
      if (got.size() != mq.size() || d_unstable) begin
        errors++;
        $display("FAIL rnd%0d_drain: len=%0d want %0d unstable=%0b",
                 r, got.size(), mq.size(), d_unstable);
      end
      for (int i = 0; i < got.size() && i < mq.size(); i++) begin
        vectors++;
        if (got[i] !== mq[i]) begin
          errors++;
          $display("FAIL rnd%0d_entry%0d: got %h want %h",
                   r, i, got[i], mq[i]);
        end
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    ret_valid    = 1'b0;
    ret_pc       = '0;
    ret_instr    = '0;
    ret_wb_en    = 1'b0;
    ret_wb_addr  = '0;
    ret_wb_data  = '0;
    cfg_mode     = 1'b0;
    cfg_trig_en  = 1'b0;
    cfg_trig_pc  = '0;
    cfg_post_cnt = '0;
    cmd_arm      = 1'b0;
    cmd_stop     = 1'b0;
    cmd_clear    = 1'b0;
    rd_ready     = 1'b0;
    model_clear();
    test_reset();
    test_wrap_basic();
    test_wrap_overflow();
    test_stop_full();
    test_trigger_post();
    test_post_zero();
    test_reset_mid_post();
    test_clear_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
